// File: rtl/alu_response_checker_pkg.sv
// Shared definitions for the ALU response checker: datapath width, default
// MISR feedback mask and the checker state encoding.
package alu_response_checker_pkg;

  localparam int ALU_WIDTH = 6;

  // Feedback mask XORed in whenever the bit shifted out of the MSB is 1
  localparam logic [ALU_WIDTH-1:0] MISR_POLY = 6'b100001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } checker_state_t;

endpackage

// File: rtl/alu_response_checker_if.sv
// Control/response bundle between the self-test controller (master) and the
// ALU response checker (slave).
interface alu_response_checker_if
  import alu_response_checker_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic             result_valid;
  logic [WIDTH-1:0] result_in;
  logic [WIDTH-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [WIDTH-1:0] signature;
  logic [3:0]       vec_count;

  modport master (
    output start, result_valid, result_in, golden_sig,
    input  busy, done, pass, fail, signature, vec_count
  );

  modport slave (
    input  start, result_valid, result_in, golden_sig,
    output busy, done, pass, fail, signature, vec_count
  );

endinterface

// File: rtl/alu_response_checker_misr6.sv
// Multiple-input signature register: shifts left, folds the feedback mask in
// when the outgoing MSB is set, and XORs the new result word in.
module alu_response_checker_misr6
  import alu_response_checker_pkg::*;
#(
  parameter int               WIDTH = ALU_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_next;

  // Next signature value for one compacted word
  always_comb begin
    sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data_in;
  end

  // Signature register; clear wins over enable so a new run starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/alu_response_checker.sv
// ALU response checker: compacts NUM_VECTORS result words into a MISR
// signature, then compares against golden_sig and reports pass/fail.
// Optional build macro CHECKER_TIMEOUT_EN adds an idle timeout (TIMEOUT
// consecutive COLLECT cycles without a valid result forces DONE with fail).
module alu_response_checker
  import alu_response_checker_pkg::*;
#(
  parameter int               WIDTH       = ALU_WIDTH,
  parameter int               NUM_VECTORS = 8,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(MISR_POLY)
`ifdef CHECKER_TIMEOUT_EN
  , parameter int             TIMEOUT     = 64
`endif
)(
  input logic                  clk,
  input logic                  reset,
  alu_response_checker_if.slave bus
);

  localparam logic [3:0] LAST_COUNT = 4'(NUM_VECTORS);

  checker_state_t   state_q;
  checker_state_t   state_d;
  logic [3:0]       vec_count_q;
  logic             pass_q;
  logic             fail_q;
  logic [WIDTH-1:0] sig;
  logic             in_collect;
  logic             accept;
  logic             start_run;
  logic             timeout_hit;

  assign in_collect = (state_q == ST_COLLECT);
  assign accept     = in_collect && bus.result_valid && (vec_count_q != LAST_COUNT);
  assign start_run  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CHECKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt_q;

  assign timeout_hit = in_collect && !bus.result_valid &&
                       (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

  // Counts consecutive empty COLLECT cycles; any accepted vector restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else if (start_run || accept) begin
      idle_cnt_q <= '0;
    end else if (in_collect) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (accept && (vec_count_q == LAST_COUNT - 4'd1)) begin
          state_d = ST_COMPARE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_COMPARE: state_d = ST_DONE;
      ST_DONE:    if (bus.start) state_d = ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Accepted-vector counter; cannot pass NUM_VECTORS because accept stops there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_count_q <= '0;
    end else if (start_run) begin
      vec_count_q <= '0;
    end else if (accept) begin
      vec_count_q <= vec_count_q + 4'd1;
    end
  end

  // Verdict register: set once in COMPARE (or by timeout) and held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (start_run) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (state_q == ST_COMPARE) begin
      pass_q <= (sig == bus.golden_sig);
      fail_q <= (sig != bus.golden_sig);
    end else if (timeout_hit) begin
      pass_q <= 1'b0;
      fail_q <= 1'b1;
    end
  end

  alu_response_checker_misr6 #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_run),
    .enable  (accept),
    .data_in (bus.result_in),
    .sig     (sig)
  );

  assign bus.busy      = (state_q == ST_COLLECT) || (state_q == ST_COMPARE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.signature = sig;
  assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Testbench for alu_response_checker: directed spec streams plus randomized
// runs checked against a signature model computed from the compaction rule.
// Build with CHECKER_TIMEOUT_EN defined to exercise the idle timeout.
module tb_alu_response_checker;

  logic clk;
  logic reset;
  int   n_vectors;
  int   n_miscompares;

  logic [5:0] stream [8];

  alu_response_checker_if #(.WIDTH(6)) bus ();

  alu_response_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference signature of the first n words of stream, using integer
  // arithmetic: multiply by two modulo 64, fold in 33 on overflow, add the word
  function automatic logic [5:0] model_sig(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = ((s * 2) % 64) ^ ((s >= 32) ? 33 : 0) ^ int'(stream[i]);
    end
    return 6'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_directed();
    stream = '{6'b000000, 6'b001111, 6'b001111, 6'b101111,
               6'b000001, 6'b000000, 6'b111111, 6'b000001};
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) stream[i] = 6'($urandom);
  endtask

  // Start pulse (with a junk valid word that must be ignored), then the stream;
  // negative gap means a random 0..3 cycle gap between vectors
  task automatic send_stream(input int gap);
    bus.start        = 1'b1;
    bus.result_valid = 1'b1;
    bus.result_in    = 6'($urandom);
    tick();
    bus.start        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.result_valid = 1'b1;
      bus.result_in    = stream[i];
      tick();
      bus.result_valid = 1'b0;
      bus.result_in    = 6'($urandom);
      if (i < 7) repeat ((gap < 0) ? int'($urandom_range(3, 0)) : gap) tick();
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_in    = '0;
    bus.golden_sig   = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.result_valid = 1'($urandom);
      bus.result_in    = 6'($urandom);
      tick();
    end
    bus.result_valid = 1'b0;
    n_vectors++;
    if ({bus.busy, bus.done, bus.pass, bus.fail} !== 4'b0000) begin
      n_miscompares++;
      $display("[TB] FAIL reset_flags: got busy/done/pass/fail=%b expected 0000",
               {bus.busy, bus.done, bus.pass, bus.fail});
    end
    n_vectors++;
    if (bus.signature !== 6'd0 || bus.vec_count !== 4'd0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_state: got sig=%b count=%0d expected 000000/0",
               bus.signature, bus.vec_count);
    end
  endtask

  task automatic test_directed_pass();
    load_directed();
    bus.golden_sig = 6'b000100;
    send_stream(0);
    n_vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL latency_1clk: got done=%b busy=%b expected 0/1", bus.done, bus.busy);
    end
    tick();
    n_vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL latency_2clk: got done=%b busy=%b expected 1/0", bus.done, bus.busy);
    end
    n_vectors++;
    if (bus.signature !== 6'b000100 || bus.vec_count !== 4'd8) begin
      n_miscompares++;
      $display("[TB] FAIL directed_sig: got sig=%b count=%0d expected 000100/8",
               bus.signature, bus.vec_count);
    end
    n_vectors++;
    if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL directed_pass: got pass=%b fail=%b expected 1/0", bus.pass, bus.fail);
    end
  endtask

  task automatic test_directed_fail();
    load_directed();
    bus.golden_sig = 6'b000101;
    send_stream(0);
    bus.result_valid = 1'b1;
    bus.result_in    = 6'b111111;
    tick();
    bus.result_valid = 1'b0;
    n_vectors++;
    if (bus.pass !== 1'b0 || bus.fail !== 1'b1 || bus.done !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL directed_fail: got pass=%b fail=%b done=%b expected 0/1/1",
               bus.pass, bus.fail, bus.done);
    end
    n_vectors++;
    if (bus.signature !== 6'b000100) begin
      n_miscompares++;
      $display("[TB] FAIL extra_in_compare: got sig=%b expected 000100", bus.signature);
    end
  endtask

  task automatic test_zeros();
    for (int i = 0; i < 8; i++) stream[i] = 6'd0;
    bus.golden_sig = 6'd0;
    send_stream(0);
    tick();
    n_vectors++;
    if (bus.pass !== 1'b1 || bus.fail !== 1'b0 || bus.signature !== 6'd0) begin
      n_miscompares++;
      $display("[TB] FAIL zeros_pass: got pass=%b fail=%b sig=%b expected 1/0/000000",
               bus.pass, bus.fail, bus.signature);
    end
  endtask

  task automatic test_gapped();
    load_directed();
    bus.golden_sig = 6'b000100;
    send_stream(3);
    tick();
    n_vectors++;
    if (bus.signature !== 6'b000100 || bus.pass !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL gapped_sig: got sig=%b pass=%b expected 000100/1",
               bus.signature, bus.pass);
    end
    bus.result_valid = 1'b1;
    bus.result_in    = 6'b101010;
    tick();
    bus.result_valid = 1'b0;
    n_vectors++;
    if (bus.signature !== 6'b000100 || bus.vec_count !== 4'd8 || bus.done !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL ninth_in_done: got sig=%b count=%0d done=%b expected 000100/8/1",
               bus.signature, bus.vec_count, bus.done);
    end
  endtask

  task automatic test_restart_clears();
    load_random();
    bus.golden_sig = model_sig(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vectors++;
    if ({bus.done, bus.pass, bus.fail, bus.busy} !== 4'b0001 ||
        bus.signature !== 6'd0 || bus.vec_count !== 4'd0) begin
      n_miscompares++;
      $display("[TB] FAIL restart_clear: got done/pass/fail/busy=%b sig=%b count=%0d expected 0001/000000/0",
               {bus.done, bus.pass, bus.fail, bus.busy}, bus.signature, bus.vec_count);
    end
    for (int i = 0; i < 8; i++) begin
      bus.result_valid = 1'b1;
      bus.result_in    = stream[i];
      tick();
      bus.result_valid = 1'b0;
      if (i == 3) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vectors++;
        if (bus.vec_count !== 4'd4 || bus.signature !== model_sig(4) || bus.busy !== 1'b1) begin
          n_miscompares++;
          $display("[TB] FAIL start_while_busy: got count=%0d sig=%b busy=%b expected 4/%b/1",
                   bus.vec_count, bus.signature, bus.busy, model_sig(4));
        end
      end
    end
    tick();
    n_vectors++;
    if (bus.signature !== model_sig(8) || bus.pass !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL restart_run: got sig=%b pass=%b expected %b/1",
               bus.signature, bus.pass, model_sig(8));
    end
  endtask

  task automatic test_reset_mid_run();
    load_directed();
    bus.golden_sig = 6'b000100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.result_valid = 1'b1;
      bus.result_in    = stream[i];
      tick();
    end
    bus.result_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_vectors++;
    if ({bus.busy, bus.done, bus.pass, bus.fail} !== 4'b0000 ||
        bus.signature !== 6'd0 || bus.vec_count !== 4'd0) begin
      n_miscompares++;
      $display("[TB] FAIL mid_reset: got flags=%b sig=%b count=%0d expected 0000/000000/0",
               {bus.busy, bus.done, bus.pass, bus.fail}, bus.signature, bus.vec_count);
    end
    tick();
    reset = 1'b0;
    send_stream(0);
    tick();
    n_vectors++;
    if (bus.signature !== 6'b000100 || bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL after_reset_run: got sig=%b pass=%b fail=%b expected 000100/1/0",
               bus.signature, bus.pass, bus.fail);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_sig;
    logic       exp_pass;
    for (int r = 0; r < 12; r++) begin
      load_random();
      exp_sig  = model_sig(8);
      exp_pass = 1'($urandom);
      bus.golden_sig = exp_pass ? exp_sig : (exp_sig ^ 6'($urandom_range(63, 1)));
      send_stream(-1);
      tick();
      n_vectors++;
      if (bus.signature !== exp_sig || bus.pass !== exp_pass ||
          bus.fail !== !exp_pass || bus.done !== 1'b1) begin
        n_miscompares++;
        $display("[TB] FAIL random_run%0d: got sig=%b pass=%b fail=%b done=%b expected %b/%b/%b/1",
                 r, bus.signature, bus.pass, bus.fail, bus.done, exp_sig, exp_pass, !exp_pass);
      end
    end
  endtask

  task automatic test_timeout();
    int idle;
    load_random();
    bus.golden_sig = 6'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.result_valid = 1'b1;
      bus.result_in    = stream[i];
      tick();
    end
    bus.result_valid = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
    idle = 0;
    while (bus.done !== 1'b1 && idle < 300) begin
      tick();
      idle++;
    end
    n_vectors++;
    if (idle != 64) begin
      n_miscompares++;
      $display("[TB] FAIL timeout_cycles: got %0d idle cycles expected 64", idle);
    end
    n_vectors++;
    if (bus.fail !== 1'b1 || bus.pass !== 1'b0 || bus.vec_count !== 4'd3 ||
        bus.signature !== model_sig(3)) begin
      n_miscompares++;
      $display("[TB] FAIL timeout_verdict: got fail=%b pass=%b count=%0d sig=%b expected 1/0/3/%b",
               bus.fail, bus.pass, bus.vec_count, bus.signature, model_sig(3));
    end
`else
    idle = 200;
    repeat (idle) tick();
    n_vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.vec_count !== 4'd3) begin
      n_miscompares++;
      $display("[TB] FAIL no_timeout: got busy=%b done=%b count=%0d expected 1/0/3",
               bus.busy, bus.done, bus.vec_count);
    end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    test_reset();
    test_directed_pass();
    test_directed_fail();
    test_zeros();
    test_gapped();
    test_restart_clears();
    test_reset_mid_run();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
